// File: rtl/vec_pe_pkg.sv
// Shared types and lane arithmetic for the vec_addsub_pipe_pe processing element.
// Optional build macro: VEC_PE_SATURATE_EN -- lane results clamp to the signed
// range on overflow instead of wrapping modulo 2^WIDTH.
package vec_pe_pkg;

    // Operation encoding carried on the op port.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_ACC  = 2'b11
    } vec_pe_op_e;

    // Burst-accumulate state held in the S2 stage.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_e;

    // Widest lane word the shared arithmetic function supports.
    localparam int unsigned VEC_PE_MAXW = 64;

    // Signed add/sub of two w-bit words supplied sign-extended to VEC_PE_MAXW.
    // Returns {ovf, result}; result is sign-extended to VEC_PE_MAXW bits and the
    // caller keeps the low w bits. ACC uses the same path as ADD.
    function automatic logic [VEC_PE_MAXW:0] lane_addsub(
        input logic signed [VEC_PE_MAXW-1:0] x,
        input logic signed [VEC_PE_MAXW-1:0] y,
        input vec_pe_op_e                    op,
        input int unsigned                   w
    );
        logic signed [VEC_PE_MAXW+1:0] ex;
        logic signed [VEC_PE_MAXW+1:0] ey;
        logic signed [VEC_PE_MAXW+1:0] r;
        logic signed [VEC_PE_MAXW+1:0] one;
        logic signed [VEC_PE_MAXW+1:0] hi;
        logic signed [VEC_PE_MAXW+1:0] lo;
        logic signed [VEC_PE_MAXW+1:0] res;
        logic                          ovf;
        ex  = (VEC_PE_MAXW+2)'(x);
        ey  = (VEC_PE_MAXW+2)'(y);
        one = (VEC_PE_MAXW+2)'(1);
        case (op)
            OP_SUB:  r = ex - ey;
            OP_RSUB: r = ey - ex;
            default: r = ex + ey;
        endcase
        // Representable range of a w-bit two's complement word.
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        ovf = (r > hi) || (r < lo);
`ifdef VEC_PE_SATURATE_EN
        if (r > hi) begin
            res = hi;
        end else if (r < lo) begin
            res = lo;
        end else begin
            res = r;
        end
`else
        res = r;
`endif
        return {ovf, res[VEC_PE_MAXW-1:0]};
    endfunction

endpackage

// File: rtl/vec_addsub_pipe_pe_lane.sv
// vec_pe_lane: one lane of the add/sub PE -- combinational arithmetic for the
// beat sitting in S1 plus this lane's burst accumulator and sticky overflow.
// Saturation behaviour follows VEC_PE_SATURATE_EN through lane_addsub.
module vec_pe_lane
    import vec_pe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             fire_i,
    input  vec_pe_op_e       op_i,
    input  logic             last_i,
    input  logic             mask_i,
    input  logic             accum_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0]                acc_q;
    logic [WIDTH-1:0]                acc_d;
    logic                            acc_ovf_q;
    logic                            acc_ovf_d;

    logic signed [VEC_PE_MAXW-1:0]   a_x;
    logic signed [VEC_PE_MAXW-1:0]   b_x;
    logic signed [VEC_PE_MAXW-1:0]   acc_x;
    logic signed [VEC_PE_MAXW-1:0]   op_x;
    logic [VEC_PE_MAXW:0]            r_op;
    logic [VEC_PE_MAXW:0]            r_acc;
    logic [WIDTH-1:0]                op_sum;
    logic                            op_ovf;
    logic [WIDTH-1:0]                acc_sum;
    logic                            acc_step_ovf;
    logic                            unused_hi_bits;

    assign a_x   = VEC_PE_MAXW'(signed'(a_i));
    assign b_x   = VEC_PE_MAXW'(signed'(b_i));
    assign acc_x = VEC_PE_MAXW'(signed'(acc_q));

    // First step: the beat's own a op b (a+b for ACC beats).
    assign r_op   = lane_addsub(a_x, b_x, op_i, WIDTH);
    assign op_sum = r_op[WIDTH-1:0];
    assign op_ovf = r_op[VEC_PE_MAXW];

    // Second step: fold the beat's a+b into the running accumulator.
    assign op_x         = VEC_PE_MAXW'(signed'(op_sum));
    assign r_acc        = lane_addsub(acc_x, op_x, OP_ADD, WIDTH);
    assign acc_sum      = r_acc[WIDTH-1:0];
    assign acc_step_ovf = r_acc[VEC_PE_MAXW];

    // Sign-extension bits above WIDTH carry no extra information.
    assign unused_hi_bits = ^{r_op, r_acc};

    // Lane result and accumulator next-state; masked lanes pass a and hold acc.
    always_comb begin
        res_o     = a_i;
        ovf_o     = 1'b0;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        if (mask_i) begin
            if (op_i != OP_ACC) begin
                res_o = op_sum;
                ovf_o = op_ovf;
            end else if (!accum_i) begin
                res_o = op_sum;
                ovf_o = op_ovf;
                if (fire_i && !last_i) begin
                    acc_d     = op_sum;
                    acc_ovf_d = op_ovf;
                end
            end else begin
                res_o = acc_sum;
                ovf_o = acc_ovf_q | op_ovf | acc_step_ovf;
                if (fire_i) begin
                    if (last_i) begin
                        acc_d     = '0;
                        acc_ovf_d = 1'b0;
                    end else begin
                        acc_d     = acc_sum;
                        acc_ovf_d = acc_ovf_q | op_ovf | acc_step_ovf;
                    end
                end
            end
        end
    end

    // Accumulator and sticky overflow registers; reset drops any partial sum.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

endmodule

// File: rtl/vec_addsub_pipe_pe.sv
// vec_addsub_pipe_pe: two-stage lane-parallel add/sub PE with lane mask and
// burst accumulate. S1 captures the accepted beat, S2 computes and holds the
// result. Optional build macro: VEC_PE_SATURATE_EN (saturating lane results).
//
// Handshake: a beat moves in when in_valid && in_ready; a result moves out when
// out_valid && out_ready. While out_valid && !out_ready, out_valid/c/ovf hold.
// in_ready = !s1_valid || !s2_valid || out_ready, so a stall reaches the input
// one cycle after the result register fills.
module vec_addsub_pipe_pe
    import vec_pe_pkg::*;
#(
    parameter int LANES = 16,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   op,
    input  logic                         in_last,
    input  logic [LANES-1:0]             lane_mask,
    input  logic [LANES-1:0][WIDTH-1:0]  a,
    input  logic [LANES-1:0][WIDTH-1:0]  b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0][WIDTH-1:0]  c,
    output logic [LANES-1:0]             ovf,
    output pe_state_e                    dbg_state_o
);

    // S1 beat registers
    logic                         s1_valid_q, s1_valid_d;
    vec_pe_op_e                   s1_op_q, s1_op_d;
    logic                         s1_last_q, s1_last_d;
    logic [LANES-1:0]             s1_mask_q, s1_mask_d;
    logic [LANES-1:0][WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [LANES-1:0][WIDTH-1:0]  s1_b_q, s1_b_d;

    // S2 result registers
    logic                         s2_valid_q, s2_valid_d;
    logic [LANES-1:0][WIDTH-1:0]  c_q, c_d;
    logic [LANES-1:0]             ovf_q, ovf_d;

    pe_state_e                    state_q, state_d;

    logic                         s2_adv;
    logic                         fire;
    logic                         is_acc;
    logic                         emit;
    logic [LANES-1:0][WIDTH-1:0]  lane_res;
    logic [LANES-1:0]             lane_ovf;

    // S2 can take a new beat when empty or its result leaves this cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign fire     = s1_valid_q && s2_adv;
    assign is_acc   = (s1_op_q == OP_ACC);
    // Every processed beat produces a result except a non-final ACC beat.
    assign emit     = fire && !(is_acc && !s1_last_q);

    assign out_valid   = s2_valid_q;
    assign c           = c_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

    // Per-lane arithmetic and accumulators.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vec_pe_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .RESET   (RESET),
            .fire_i  (fire),
            .op_i    (s1_op_q),
            .last_i  (s1_last_q),
            .mask_i  (s1_mask_q[i]),
            .accum_i (state_q == ACCUM),
            .a_i     (s1_a_q[i]),
            .b_i     (s1_b_q[i]),
            .res_o   (lane_res[i]),
            .ovf_o   (lane_ovf[i])
        );
    end

    // Burst FSM next state: only ACC beats leaving S1 move it.
    always_comb begin
        state_d = state_q;
        if (fire && is_acc) begin
            case (state_q)
                IDLE:    if (!s1_last_q) state_d = ACCUM;
                ACCUM:   if (s1_last_q)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // S1 next state: load a new beat whenever the stage frees up.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_last_d  = s1_last_q;
        s1_mask_d  = s1_mask_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d   = vec_pe_op_e'(op);
                s1_last_d = in_last;
                s1_mask_d = lane_mask;
                s1_a_d    = a;
                s1_b_d    = b;
            end
        end
    end

    // S2 next state: capture lane results on emit, hold while stalled.
    always_comb begin
        s2_valid_d = s2_valid_q;
        c_d        = c_q;
        ovf_d      = ovf_q;
        if (s2_adv) begin
            s2_valid_d = emit;
            if (emit) begin
                c_d   = lane_res;
                ovf_d = lane_ovf;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // S1 pipeline registers.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_last_q  <= 1'b0;
            s1_mask_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_last_q  <= s1_last_d;
            s1_mask_q  <= s1_mask_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
        end
    end

    // S2 result registers.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            ovf_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            c_q        <= c_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_vec_addsub_pipe_pe.sv
// Bench for vec_addsub_pipe_pe (LANES=16, WIDTH=32). Honours VEC_PE_SATURATE_EN
// when choosing expected overflow results.
module tb_vec_addsub_pipe_pe;
    import vec_pe_pkg::*;

    localparam int LANES = 16;
    localparam int WIDTH = 32;
    localparam int VW    = LANES * WIDTH;
    localparam logic [LANES-1:0] ALL = '1;

    typedef logic [VW-1:0] vec_t;

    logic             clk = 1'b0;
    logic             RESET;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             in_last;
    logic [LANES-1:0] lane_mask;
    vec_t             a;
    vec_t             b;
    logic             out_valid;
    logic             out_ready;
    vec_t             c;
    logic [LANES-1:0] ovf;
    pe_state_e        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    vec_t             exp_c_q[$];
    logic [LANES-1:0] exp_ovf_q[$];
    int               exp_lat_q[$];

    logic             held_v = 1'b0;
    vec_t             held_c;
    logic [LANES-1:0] held_ovf;

    vec_addsub_pipe_pe #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .in_last     (in_last),
        .lane_mask   (lane_mask),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .ovf         (ovf),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic vec_t fill(input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] step);
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = base + WIDTH'(i) * step;
        return v;
    endfunction

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [1:0] o, input logic last, input logic [LANES-1:0] m,
                        input vec_t av, input vec_t bv, input bit push,
                        input vec_t ec, input logic [LANES-1:0] eo, input bit lat);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        op        = o;
        in_last   = last;
        lane_mask = m;
        a         = av;
        b         = bv;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end else if (push) begin
            exp_c_q.push_back(ec);
            exp_ovf_q.push_back(eo);
            exp_lat_q.push_back(lat ? cyc + 2 : -1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_c_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check_val("drain_queue_empty", 64'(exp_c_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!RESET) begin
            held_v <= 1'b0;
        end else begin
            if (held_v) begin
                check_val("stall_valid_held", 64'(out_valid), 64'd1);
                check_vec("stall_c_stable", c, held_c);
                check_val("stall_ovf_stable", 64'(ovf), 64'(held_ovf));
            end
            held_v <= out_valid && !out_ready;
            held_c <= c;
            held_ovf <= ovf;
            if (out_valid && out_ready) begin
                if (exp_c_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got c=%h with empty queue", c);
                end else begin
                    vec_t             ec;
                    logic [LANES-1:0] eo;
                    int               el;
                    ec = exp_c_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    el = exp_lat_q.pop_front();
                    check_vec("result_c", c, ec);
                    check_val("result_ovf", 64'(ovf), 64'(eo));
                    if (el >= 0) check_val("latency_cycle", 64'(cyc), 64'(el));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t             ev;
        vec_t             z;
        logic [WIDTH-1:0] big_res;
        logic [WIDTH-1:0] sub_res;
        z         = '0;
        RESET     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        in_last   = 1'b0;
        lane_mask = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out_valid", 64'(out_valid), 64'd0);
        check_vec("reset_c", c, z);
        check_val("reset_ovf", 64'(ovf), 64'd0);
        check_val("reset_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #1;
        RESET = 1'b1;
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // 1. ADD a=i, b=100 with latency check
        send(OP_ADD, 1'b0, ALL, fill(0, 1), fill(100, 0), 1'b1, fill(100, 1), '0, 1'b1);
        send(OP_ADD, 1'b0, ALL, fill(7, 2), fill(1, 0), 1'b1, fill(8, 2), '0, 1'b1);
        drain();

        // 2. SUB / RSUB, a=5 b=7
        send(OP_SUB, 1'b0, ALL, fill(5, 0), fill(7, 0), 1'b1, fill(32'hFFFF_FFFE, 0), '0, 1'b0);
        send(OP_RSUB, 1'b0, ALL, fill(5, 0), fill(7, 0), 1'b1, fill(2, 0), '0, 1'b0);
        drain();

        // 3. ACC burst of 4 beats, a=b=1 -> 8
        repeat (3) send(OP_ACC, 1'b0, ALL, fill(1, 0), fill(1, 0), 1'b0, z, '0, 1'b0);
        check_val("accum_state", 64'(dbg_state), 64'(ACCUM));
        send(OP_ACC, 1'b1, ALL, fill(1, 0), fill(1, 0), 1'b1, fill(8, 0), '0, 1'b0);
        drain();
        check_val("idle_after_burst", 64'(dbg_state), 64'(IDLE));

        // ADD inside a burst leaves the accumulator alone: 2 + (5) + 2 -> 4
        send(OP_ACC, 1'b0, ALL, fill(1, 0), fill(1, 0), 1'b0, z, '0, 1'b0);
        send(OP_ADD, 1'b0, ALL, fill(2, 0), fill(3, 0), 1'b1, fill(5, 0), '0, 1'b0);
        send(OP_ACC, 1'b1, ALL, fill(1, 0), fill(1, 0), 1'b1, fill(4, 0), '0, 1'b0);
        drain();

        // Masked ACC: lanes 0-7 accumulate to 8, lanes 8-15 pass a=2
        ev = fill(2, 0);
        for (int i = 0; i < 8; i++) ev[i*WIDTH +: WIDTH] = 32'd8;
        send(OP_ACC, 1'b0, 16'h00FF, fill(2, 0), fill(2, 0), 1'b0, z, '0, 1'b0);
        send(OP_ACC, 1'b1, 16'h00FF, fill(2, 0), fill(2, 0), 1'b1, ev, '0, 1'b0);
        drain();

        // 4. Overflow boundaries
`ifdef VEC_PE_SATURATE_EN
        big_res = 32'h7FFF_FFFF;
        sub_res = 32'h8000_0000;
`else
        big_res = 32'h8000_0000;
        sub_res = 32'h7FFF_FFFF;
`endif
        send(OP_ADD, 1'b0, ALL, fill(32'h7FFF_FFFF, 0), fill(1, 0), 1'b1, fill(big_res, 0), ALL, 1'b0);
        send(OP_SUB, 1'b0, ALL, fill(32'h8000_0000, 0), fill(1, 0), 1'b1, fill(sub_res, 0), ALL, 1'b0);
        // Sticky accumulator overflow: first beat overflows, second adds 0
        send(OP_ACC, 1'b0, ALL, fill(32'h7FFF_FFFF, 0), fill(1, 0), 1'b0, z, '0, 1'b0);
        send(OP_ACC, 1'b1, ALL, fill(0, 0), fill(0, 0), 1'b1, fill(big_res, 0), ALL, 1'b0);
        drain();

        // Extra: mask lane 0 only
        ev = fill(10, 1);
        ev[WIDTH-1:0] = 32'd30;
        send(OP_ADD, 1'b0, 16'h0001, fill(10, 1), fill(20, 0), 1'b1, ev, '0, 1'b0);
        drain();

        // 5. 10 streamed ADD beats with out_ready low for 5 cycles
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(OP_ADD, 1'b0, ALL, fill(WIDTH'(1000 * k), 1), fill(WIDTH'(k), 0),
                         1'b1, fill(WIDTH'(1001 * k), 1), '0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check_val("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // 6. Reset in the middle of an ACC burst
        send(OP_ACC, 1'b0, ALL, fill(5, 0), fill(5, 0), 1'b0, z, '0, 1'b0);
        send(OP_ACC, 1'b0, ALL, fill(5, 0), fill(5, 0), 1'b0, z, '0, 1'b0);
        RESET = 1'b0;
        #1;
        check_val("midburst_out_valid", 64'(out_valid), 64'd0);
        check_vec("midburst_c", c, z);
        check_val("midburst_ovf", 64'(ovf), 64'd0);
        check_val("midburst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #1;
        RESET = 1'b1;
        check_val("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(OP_ACC, 1'b1, ALL, fill(3, 0), fill(3, 0), 1'b1, fill(6, 0), '0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
